// File: rtl/aes128_rand_gen.sv
// aes128_rand_gen: randomness source for a masked AES inverter, built from 32-bit Galois LFSR lanes.
// Optional repeated-word health monitor is built in when AES128_RAND_HEALTH_EN is defined.
module aes128_rand_gen #(
    parameter int  NUM_SHARES    = 2,
    parameter int  STAGE_TYPE    = 3,   // 1 = HPC1, 3 = HPC3
    parameter int  WARMUP_CYCLES = 32,
    localparam int PAIRS = NUM_SHARES * (NUM_SHARES - 1) / 2,
    localparam int S1    = 8 * PAIRS,
    localparam int S2    = ((STAGE_TYPE == 1) ? 22 : 14) * PAIRS,
    localparam int S3    = 10 * PAIRS,
    localparam int W     = S1 + S2 + S3,
    localparam int L     = (W + 31) / 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          seed_valid_i,
    input  logic [31:0]   seed_data_i,
    output logic          seed_ready_o,
    output logic [S1-1:0] rand_s1_o,
    output logic [S2-1:0] rand_s2_o,
    output logic [S3-1:0] rand_s3_o,
    output logic          rand_valid_o,
    input  logic          rand_ready_i,
    output logic          fault_o
);

    localparam int BW  = (L > 1) ? $clog2(L) : 1;
    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    typedef enum logic [1:0] {ST_UNSEEDED, ST_SEED, ST_WARMUP, ST_RUN} state_t;

    localparam state_t ST_AFTER_SEED = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_lane [L];
    logic [32*L-1:0] w_cat;
    logic [BW-1:0]   r_beat_cnt;
    logic [BW-1:0]   w_load_idx;
    logic [WCW-1:0]  r_warm_cnt;
    logic            w_load;
    logic            w_step;
    logic            w_seed_acc;
    logic            w_valid;
    logic [31:0]     w_seed_fix;

    // An all-zero lane would lock the LFSR, so a zero beat is promoted to 1.
    assign w_seed_fix   = (seed_data_i == 32'h0) ? 32'h1 : seed_data_i;
    assign seed_ready_o = !rst_i && (r_state != ST_WARMUP);
    assign w_seed_acc   = seed_valid_i && seed_ready_o;
    assign rand_valid_o = w_valid;

    always_comb begin
        w_cat = '0;
        for (int k = 0; k < L; k++) w_cat[32*k +: 32] = r_lane[k];
    end

    assign rand_s1_o = w_cat[S1-1:0];
    assign rand_s2_o = w_cat[S1 +: S2];
    assign rand_s3_o = w_cat[S1+S2 +: S3];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_UNSEEDED;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_idx   = '0;
        w_step       = 1'b0;
        case (r_state)
            ST_UNSEEDED: begin
                if (w_seed_acc) begin
                    w_load       = 1'b1;
                    w_next_state = (L == 1) ? ST_AFTER_SEED : ST_SEED;
                end
            end
            ST_SEED: begin
                if (w_seed_acc) begin
                    w_load     = 1'b1;
                    w_load_idx = r_beat_cnt;
                    if (r_beat_cnt == BW'(L - 1)) w_next_state = ST_AFTER_SEED;
                end
            end
            ST_WARMUP: begin
                w_step = 1'b1;
                if (r_warm_cnt == '0) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                // Reseed wins over a simultaneous consumer pull.
                if (w_seed_acc) begin
                    w_load       = 1'b1;
                    w_next_state = (L == 1) ? ST_AFTER_SEED : ST_SEED;
                end else if (rand_ready_i && w_valid) begin
                    w_step = 1'b1;
                end
            end
            default: w_next_state = ST_UNSEEDED;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < L; k++) r_lane[k] <= '0;
            r_beat_cnt <= '0;
            r_warm_cnt <= '0;
        end else begin
            for (int k = 0; k < L; k++) begin
                if (w_load && (w_load_idx == BW'(k))) r_lane[k] <= w_seed_fix;
                else if (w_step)                      r_lane[k] <= lfsr_step(r_lane[k]);
            end
            if (w_load) r_beat_cnt <= w_load_idx + 1'b1;
            if (w_next_state == ST_WARMUP && r_state != ST_WARMUP)
                r_warm_cnt <= WCW'(WARMUP_CYCLES - 1);
            else if (r_state == ST_WARMUP && r_warm_cnt != '0)
                r_warm_cnt <= r_warm_cnt - 1'b1;
        end
    end

`ifdef AES128_RAND_HEALTH_EN
    logic [32*L-1:0] w_cat_nxt;
    logic [1:0]      r_rep_cnt;
    logic            r_fault;

    always_comb begin
        w_cat_nxt = '0;
        for (int k = 0; k < L; k++) w_cat_nxt[32*k +: 32] = lfsr_step(r_lane[k]);
    end

    // Three equal transitions in a row means four identical words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rep_cnt <= '0;
            r_fault   <= 1'b0;
        end else if (w_load) begin
            r_rep_cnt <= '0;
            r_fault   <= 1'b0;
        end else if (w_step && r_state == ST_RUN) begin
            if (w_cat_nxt[W-1:0] == w_cat[W-1:0]) begin
                if (r_rep_cnt == 2'd2) r_fault   <= 1'b1;
                else                   r_rep_cnt <= r_rep_cnt + 2'd1;
            end else begin
                r_rep_cnt <= '0;
            end
        end
    end

    assign fault_o = r_fault;
    assign w_valid = (r_state == ST_RUN) && !r_fault;
`else
    assign fault_o = 1'b0;
    assign w_valid = (r_state == ST_RUN);
`endif

endmodule

// File: doc/aes128_rand_gen.md
AES128_RAND_GEN -- requirements
Module: aes128_rand_gen

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2, giving the masking order plus one; the legal range is 2..5.
REQ-002 SHALL have parameter STAGE_TYPE, default HPC3, selecting the stage-2 gadget type (HPC1 or HPC3).
REQ-003 SHALL have parameter WARMUP_CYCLES, default 32, giving the number of discarded LFSR steps after seeding.
REQ-004 SHALL derive the following widths:
- S1 = stage-1 random count, S2 = stage-2 random count (for STAGE_TYPE), S3 = stage-3 random count.
- W = S1+S2+S3 (equal to the inverter's total random count).
- L = ceil(W/32).
- For the defaults: S1=8, S2=14, S3=10, W=32, L=1.
REQ-005 SHALL use one clock and an asynchronous, active-high reset:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL provide the seed input ports:
- seed_valid_i  in  1  seed beat valid.
- seed_data_i  in  32  seed beat.
- seed_ready_o  out  1  seed beat accepted.
REQ-007 SHALL provide the random output ports:
- rand_s1_o  out  S1  stage-1 randoms.
- rand_s2_o  out  S2  stage-2 randoms.
- rand_s3_o  out  S3  stage-3 randoms.
REQ-008 SHALL provide the output handshake ports:
- rand_valid_o  out  1  randoms valid.
- rand_ready_i  in  1  consumer takes the current word.
REQ-009 SHALL provide fault_o  out  1  health fault (see Configuration).

Function
REQ-010 SHALL hold L lanes, each a 32-bit right-shift Galois LFSR.
- Step rule: next = (s>>1) XOR (s[0] ? 32'h80200003 : 0).
REQ-011 SHALL form the output word as {lane L-1, ..., lane 0} truncated to W bits.
- rand_s1_o = bits [S1-1:0].
- rand_s2_o = the next S2 bits.
- rand_s3_o = the top S3 bits.
REQ-012 SHALL implement the FSM states UNSEEDED, SEED, WARMUP and RUN.
REQ-013 In UNSEEDED, seed_ready_o SHALL be 1 and rand_valid_o SHALL be 0; the first seed beat enters SEED.
REQ-014 In SEED, seed_ready_o SHALL be 1.
- Beat k (k=0..L-1) loads lane k.
- A beat of 32'h0 SHALL load 32'h1 instead.
- A beat counter counts beats; after beat L-1, enter WARMUP.
- If WARMUP_CYCLES=0, enter RUN directly instead.
REQ-015 In WARMUP, all lanes SHALL step once per cycle for exactly WARMUP_CYCLES cycles, then enter RUN; seed_ready_o=0 and rand_valid_o=0.
REQ-016 In RUN, rand_valid_o SHALL be 1.
- All lanes step on a cycle with rand_ready_i=1, so each accepted word is used exactly once.
- The output holds stable while rand_ready_i=0.
REQ-017 In RUN, seed_ready_o SHALL be 1; an accepted seed beat SHALL reseed.
- On the reseed cycle: drop rand_valid_o on the next cycle, load lane 0, and enter SEED (or WARMUP when L=1).
- The reseed takes priority over a simultaneous rand_ready_i.
REQ-018 Latency SHALL be 1 cycle from an accepted rand_ready_i to the next word appearing.
REQ-019 The output SHALL be registered only; no combinational path SHALL exist from rand_ready_i to rand_*_o.

Reset
REQ-020 Reset SHALL place the FSM in UNSEEDED.
REQ-021 Reset SHALL clear all lanes, counters and fault_o to 0.
REQ-022 Reset SHALL drive rand_valid_o=0 and seed_ready_o=0 while rst_i=1.
REQ-023 Reset asserted mid-seed or mid-warmup SHALL discard the partial state; a full seed sequence is required afterwards.

Configuration
REQ-024 With macro AES128_RAND_HEALTH_EN defined, the block SHALL compare each newly stepped word with the previous one in RUN.
- On 4 consecutive identical words, set fault_o=1 (sticky until reset or reseed).
- While fault_o=1, force rand_valid_o=0.
REQ-025 Without AES128_RAND_HEALTH_EN, the block SHALL tie fault_o to 0 and SHALL contain no comparison logic.

Verification
REQ-026 Defaults with WARMUP_CYCLES=0 -> required response:
- Stimulus: seed beat 32'h00000001.
- Next cycle: rand_valid_o=1, rand_s1_o=8'h01, rand_s2_o=0, rand_s3_o=0.
REQ-027 Continue REQ-026 -> required response:
- Stimulus: assert rand_ready_i for one cycle.
- Response: rand_s1_o=8'h03, rand_s2_o=14'h2000, rand_s3_o=10'h200.
REQ-028 Seed beat 32'h0 -> behaves identically to seed 32'h1.
REQ-029 WARMUP_CYCLES=32, seed 1 -> required response:
- rand_valid_o rises exactly 33 cycles after the seed beat.
- The first word equals the LFSR state after 32 software-model steps.
REQ-030 In RUN with rand_ready_i=0 for 10 cycles -> output is stable; then assert seed_valid_i and rand_ready_i together -> reseed wins and rand_valid_o=0 on the next cycle.
REQ-031 NUM_SHARES=3, STAGE_TYPE=HPC1 -> required response:
- Widths S1=24, S2=66, S3=30, W=120, L=4.
- After 4 beats, lane k holds beat k.
- Pulsing rst_i after the 2nd beat returns the FSM to UNSEEDED.
